// File: rtl/can_tx_scheduler.sv
// Multi-mailbox CAN transmit scheduler: picks the pending mailbox with the lowest ID,
// hands it to the controller, retries on start timeout and reports done/fail per mailbox.
module can_tx_scheduler #(
  parameter int NUM_MB        = 4,
  parameter int START_TIMEOUT = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_idx,
  input  logic [10:0]       wr_id,
  input  logic [3:0]        wr_dlc,
  input  logic [63:0]       wr_data,
  input  logic              abort_en,
  input  logic [2:0]        abort_idx,
  output logic              tx_request,
  output logic [10:0]       tx_id,
  output logic [3:0]        tx_dlc,
  output logic [63:0]       tx_data,
  input  logic              tx_idle,
  output logic [NUM_MB-1:0] pending,
  output logic              done_pulse,
  output logic              fail_pulse,
  output logic [2:0]        evt_idx,
  output logic              busy
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_REQ, S_WAIT_START, S_WAIT_DONE, S_DONE, S_FAIL
  } state_t;

  state_t            state_q;
  logic [10:0]       id_q   [NUM_MB];
  logic [3:0]        dlc_q  [NUM_MB];
  logic [63:0]       data_q [NUM_MB];
  logic [NUM_MB-1:0] pending_q, pending_d, cand;
  logic [2:0]        active_q, evt_q;
  logic [TW-1:0]     timer_q;
  logic [RW-1:0]     retry_q;
  logic              tx_request_q, done_q, fail_q;
  logic [10:0]       tx_id_q;
  logic [3:0]        tx_dlc_q;
  logic [63:0]       tx_data_q;

  logic wr_valid, ab_valid, guard_state, wr_accept, ab_win, ab_active, ab_clear, finish;

  assign wr_valid    = wr_en    && ({1'b0, wr_idx}    < 4'(NUM_MB));
  assign ab_valid    = abort_en && ({1'b0, abort_idx} < 4'(NUM_MB));
  assign guard_state = (state_q == S_WAIT_START) || (state_q == S_WAIT_DONE);
  assign wr_accept   = wr_valid && !(guard_state && (wr_idx == active_q));
  assign ab_win      = ab_valid && !(wr_accept && (wr_idx == abort_idx));
  assign ab_active   = ab_win && (abort_idx == active_q) &&
                       ((state_q == S_REQ) || (state_q == S_WAIT_START));
  // Once the frame is on the bus the abort can no longer take effect.
  assign ab_clear    = ab_win && !((abort_idx == active_q) && (state_q == S_WAIT_DONE));
  assign finish      = (state_q == S_DONE) || (state_q == S_FAIL);

  for (genvar gi = 0; gi < NUM_MB; gi++) begin : g_pend
    assign cand[gi]      = pending_q[gi] && !(ab_clear && (abort_idx == 3'(gi)));
    assign pending_d[gi] = (wr_accept && (wr_idx == 3'(gi))) ||
                           (cand[gi] && !(finish && (active_q == 3'(gi))));
  end

  logic        sel_found;
  logic [2:0]  sel_idx;
  logic [10:0] sel_id;
  logic [3:0]  sel_dlc;
  logic [63:0] sel_data;

  // Strict less-than keeps the lowest index on equal IDs.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_id    = '0;
    sel_dlc   = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (cand[i] && (!sel_found || (id_q[i] < sel_id))) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
        sel_id    = id_q[i];
        sel_dlc   = dlc_q[i];
        sel_data  = data_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MB; i++) begin
        id_q[i]   <= '0;
        dlc_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (wr_accept) begin
      for (int i = 0; i < NUM_MB; i++) begin
        if (wr_idx == 3'(i)) begin
          id_q[i]   <= wr_id;
          dlc_q[i]  <= wr_dlc;
          data_q[i] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      active_q     <= '0;
      evt_q        <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      tx_request_q <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      tx_id_q      <= '0;
      tx_dlc_q     <= '0;
      tx_data_q    <= '0;
    end else begin
      pending_q    <= pending_d;
      tx_request_q <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      case (state_q)
        S_IDLE: if ((|pending_q) && tx_idle) state_q <= S_SELECT;
        S_SELECT: begin
          if (sel_found) begin
            active_q     <= sel_idx;
            tx_id_q      <= sel_id;
            tx_dlc_q     <= sel_dlc;
            tx_data_q    <= sel_data;
            tx_request_q <= 1'b1;
            state_q      <= S_REQ;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_REQ: begin
          timer_q <= '0;
          if (ab_active) begin
            retry_q <= '0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (ab_active) begin
            retry_q <= '0;
            state_q <= S_IDLE;
          end else if (!tx_idle) begin
            state_q <= S_WAIT_DONE;
          end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_q      <= retry_q + RW'(1);
              tx_request_q <= 1'b1;
              state_q      <= S_REQ;
            end else begin
              fail_q  <= 1'b1;
              evt_q   <= active_q;
              state_q <= S_FAIL;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (tx_idle) begin
            done_q  <= 1'b1;
            evt_q   <= active_q;
            state_q <= S_DONE;
          end
        end
        S_DONE, S_FAIL: begin
          retry_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_request = tx_request_q;
  assign tx_id      = tx_id_q;
  assign tx_dlc     = tx_dlc_q;
  assign tx_data    = tx_data_q;
  assign pending    = pending_q;
  assign done_pulse = done_q;
  assign fail_pulse = fail_q;
  assign evt_idx    = evt_q;
  assign busy       = (state_q != S_IDLE);

endmodule
